// File: rtl/ex_mem_estagio.sv
// ex_mem_estagio: EX/MEM pipeline stage behind the ALU.
// Holds up to two ALU results with their memory and write-back controls in a
// FIFO skid buffer, using valid/ready handshakes on both sides.
// A conditional branch is resolved from the captured zero flag. It produces a
// one-cycle taken pulse together with the target address.
// Optional build macro: EX_MEM_FWD_EN adds the fwd_valido, fwd_reg and
// fwd_dado outputs. They expose the head entry to the ALU operand forwarding mux.
module ex_mem_estagio #(
  parameter int LARGURA  = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                entrada_valido,
  output logic                entrada_pronto,
  input  logic [LARGURA-1:0]  alu_resultado,
  input  logic                zero,
  input  logic [LARGURA-1:0]  dado_escrita,
  input  logic [REG_BITS-1:0] reg_destino,
  input  logic [4:0]          ctrl_in,
  input  logic [LARGURA-1:0]  pc_alvo,
  input  logic                flush,
  output logic                saida_valido,
  input  logic                saida_pronto,
  output logic [LARGURA-1:0]  saida_resultado,
  output logic [LARGURA-1:0]  saida_dado,
  output logic [REG_BITS-1:0] saida_reg,
  output logic [4:0]          saida_ctrl,
  output logic                desvio_tomado,
  output logic [LARGURA-1:0]  pc_desvio
`ifdef EX_MEM_FWD_EN
  ,
  output logic                fwd_valido,
  output logic [REG_BITS-1:0] fwd_reg,
  output logic [LARGURA-1:0]  fwd_dado
`endif
);

  // Control bit positions inside {branch, mem_read, mem_write, reg_write, mem_to_reg}
  localparam int CTRL_BRANCH    = 4;
  localparam int CTRL_MEM_READ  = 3;
  localparam int CTRL_REG_WRITE = 1;

  logic [LARGURA-1:0]  mem_resultado [2];
  logic [LARGURA-1:0]  mem_dado      [2];
  logic [REG_BITS-1:0] mem_reg       [2];
  logic [4:0]          mem_ctrl      [2];

  logic [1:0] contador;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       push;
  logic       pop;

  // Both handshake outputs depend only on the occupancy register, so no input
  // has a combinational path through to them.
  assign entrada_pronto = (contador != 2'd2);
  assign saida_valido   = (contador != 2'd0);

  assign push = entrada_valido & entrada_pronto & ~flush;
  assign pop  = saida_valido & saida_pronto & ~flush;

  // The head entry drives the payload outputs. When the buffer is empty they
  // show whatever the storage last held.
  assign saida_resultado = mem_resultado[rd_ptr];
  assign saida_dado      = mem_dado[rd_ptr];
  assign saida_reg       = mem_reg[rd_ptr];
  assign saida_ctrl      = mem_ctrl[rd_ptr];

  // Occupancy, pointers and the branch pulse. Flush overrides both push and pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      contador      <= 2'd0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      desvio_tomado <= 1'b0;
      pc_desvio     <= '0;
    end else if (flush) begin
      contador      <= 2'd0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      desvio_tomado <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // right-hand side here sees the values from before the clock edge.
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   contador <= contador + 2'd1;
        2'b01:   contador <= contador - 2'd1;
        default: contador <= contador;
      endcase
      desvio_tomado <= push & ctrl_in[CTRL_BRANCH] & zero;
      if (push && ctrl_in[CTRL_BRANCH] && zero) pc_desvio <= pc_alvo;
    end
  end

  // Entry storage: an accepted entry is written at the tail slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the storage is reset on purpose. The payload outputs must read
      // zero after reset, and they are taken straight from these slots.
      for (int i = 0; i < 2; i++) begin
        mem_resultado[i] <= '0;
        mem_dado[i]      <= '0;
        mem_reg[i]       <= '0;
        mem_ctrl[i]      <= '0;
      end
    end else if (push) begin
      mem_resultado[wr_ptr] <= alu_resultado;
      mem_dado[wr_ptr]      <= dado_escrita;
      mem_reg[wr_ptr]       <= reg_destino;
      mem_ctrl[wr_ptr]      <= ctrl_in;
    end
  end

`ifdef EX_MEM_FWD_EN
  // Forwarding view of the head entry. Loads are excluded because their data
  // is not yet known, and writes to register 0 are excluded because r0 is
  // never written.
  assign fwd_valido = saida_valido & saida_ctrl[CTRL_REG_WRITE] &
                      ~saida_ctrl[CTRL_MEM_READ] & (saida_reg != '0);
  assign fwd_reg    = saida_reg;
  assign fwd_dado   = saida_resultado;
`endif

endmodule

// File: doc/ex_mem_estagio.md
# ex_mem_estagio

EX/MEM pipeline stage directly downstream of the ALU. Captures the ALU result, zero flag, store data, destination register and memory/write-back control bits into a 2-entry skid buffer with valid/ready handshakes on both sides. Resolves conditional branches from the captured zero flag. Feeds the data-memory stage.

## Interface
Parameters:
- LARGURA, 32, data width of result, store data and branch target
- REG_BITS, 5, register-index width

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- entrada_valido  in  1  ALU stage offers an entry
- entrada_pronto  out  1  stage can accept; equals (contador != 2), from registers only
- alu_resultado  in  LARGURA  ALU result
- zero  in  1  ALU zero flag
- dado_escrita  in  LARGURA  store data (rt value)
- reg_destino  in  REG_BITS  write-back register index
- ctrl_in  in  5  {branch, mem_read, mem_write, reg_write, mem_to_reg}
- pc_alvo  in  LARGURA  branch target computed in EX
- flush  in  1  discard all held entries and the entry offered this cycle
- saida_valido  out  1  head entry valid; equals (contador != 0)
- saida_pronto  in  1  memory stage accepts head
- saida_resultado, saida_dado, saida_reg, saida_ctrl  out  LARGURA/LARGURA/REG_BITS/5  head-entry payload
- desvio_tomado  out  1  one-cycle pulse: accepted entry had branch=1 and zero=1
- pc_desvio  out  LARGURA  pc_alvo of that branch, valid while desvio_tomado=1

## Operation
- Storage: 2 entries, FIFO order, 2-bit contador in {0,1,2}; head pointer toggles on pop.
- Push: entrada_valido & entrada_pronto & !flush. Pop: saida_valido & saida_pronto & !flush.
- Push+pop same cycle: contador unchanged; new entry queued behind the remaining one (or becomes head when contador was 1).
- Full (contador=2): entrada_pronto=0; offered entry is not taken and must be held by the ALU stage.
- Empty: saida_valido=0; saida_* payload outputs hold last value (don't-care to consumer).
- Flush: highest priority; next cycle contador=0, no push, no pop, desvio_tomado=0. Stores held in buffer are dropped.
- Branch: on push with ctrl branch=1 and zero=1, desvio_tomado=1 and pc_desvio=pc_alvo in the next cycle only. Branch entries are still enqueued (consumer ignores them for memory).
- Widths: all payload passes unmodified; no arithmetic except contador and pointers (pointers wrap mod 2).

## Timing
- Reset (async assert, sync-safe release): contador=0, pointers=0, saida_valido=0, entrada_pronto=1, desvio_tomado=0, pc_desvio=0, all saida_* payload=0.
- Latency: push at edge N into empty buffer -> saida_valido=1 with that payload after edge N.
- Throughput: 1 entry/cycle sustained when saida_pronto=1.
- No combinational path from saida_pronto to entrada_pronto, nor from any input to saida_valido.
- desvio_tomado: exactly one cycle, cycle after acceptance; never two consecutive unless two branch pushes occur consecutively.
- Reset asserted mid-transfer: all state cleared immediately; in-flight entries lost.

## Configuration
- EX_MEM_FWD_EN defined: adds outputs fwd_valido (1), fwd_reg (REG_BITS), fwd_dado (LARGURA) reflecting the head entry: fwd_valido = saida_valido & reg_write & !mem_read & (saida_reg != 0); used by the ALU operand mux for forwarding. Reset value 0.
- Undefined: ports absent; no forwarding logic.

## Test plan
- Reset low mid-run with contador=2 -> immediately saida_valido=0, entrada_pronto=1, desvio_tomado=0.
- Push result 0x0000_0005, reg 9, saida_pronto=1 continuously -> saida_resultado=0x5, saida_reg=9 one cycle later; 10 back-to-back pushes drain at 1/cycle in order.
- saida_pronto=0, push A then B -> contador=2, entrada_pronto=0, C held; raise saida_pronto -> A, B, C emerge in order, none lost or duplicated.
- Push branch=1, zero=1, pc_alvo=0x0040_0020 -> desvio_tomado=1, pc_desvio=0x0040_0020 for exactly one cycle; branch=1, zero=0 -> no pulse.
- contador=2 plus flush with entrada_valido=1 (branch taken) -> next cycle contador=0, saida_valido=0, no desvio_tomado.
- EX_MEM_FWD_EN: head reg_write=1, reg 0 -> fwd_valido=0; reg 8 -> fwd_valido=1, fwd_dado=saida_resultado.
